// File: rtl/clkgen_sched_if.sv
// Configuration handshake bundle for clkgen_sched: a valid/ready offer carrying
// period, high time and start phase, all counted in clk cycles.
interface clkgen_sched_if #(
    parameter int CNT_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_ton;
    logic [CNT_W-1:0] cfg_phase;

    modport master (output cfg_valid, cfg_period, cfg_ton, cfg_phase, input cfg_ready);
    modport slave  (input cfg_valid, cfg_period, cfg_ton, cfg_phase, output cfg_ready);
endinterface

// File: rtl/clkgen_sched.sv
// Programmable waveform generator: after an optional start phase it repeats
// HIGH for ton cycles and LOW for period-ton cycles until stopped.
// New configurations offered while running are parked in shadow registers and
// take effect at the next period boundary.
// Optional feature: define CLKGEN_SCHED_PERIOD_CNT_EN to add a 32-bit
// completed-period counter output (period_cnt).
module clkgen_sched #(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    clkgen_sched_if.slave cfg,
    input  logic          start,
    input  logic          stop,
    output logic          clk_out,
    output logic          busy,
    output logic          cfg_err
`ifdef CLKGEN_SCHED_PERIOD_CNT_EN
    ,
    output logic [31:0]   period_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, PHASE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] ONE = 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_period, act_ton, act_phase;
    logic [CNT_W-1:0] shd_period, shd_ton, shd_phase;
    logic             pending;
    logic             stop_lat;
    logic             cfg_loaded;

    logic             cfg_fire;
    logic             cfg_bad;
    logic             boundary;
    logic             stop_now;
    logic [CNT_W-1:0] nxt_period;
    logic [CNT_W-1:0] nxt_ton;

    // First state of a period: HIGH unless the high time is empty.
    function automatic state_t entry_state(input logic [CNT_W-1:0] ton);
        return (ton != '0) ? HIGH : LOW;
    endfunction

    // Counter load on entering a period; the counter holds remaining cycles minus one.
    function automatic logic [CNT_W-1:0] entry_cnt(input logic [CNT_W-1:0] period,
                                                   input logic [CNT_W-1:0] ton);
        return (ton != '0) ? (ton - ONE) : (period - ONE);
    endfunction

    assign cfg.cfg_ready = (state == IDLE) || !pending;
    assign busy          = (state != IDLE);

    // Handshake decode, period-boundary detection and the config that the next period will use.
    always_comb begin
        cfg_fire   = cfg.cfg_valid && cfg.cfg_ready;
        cfg_bad    = (cfg.cfg_period == '0) || (cfg.cfg_ton > cfg.cfg_period);
        boundary   = ((state == HIGH) && (cnt == '0) && (act_ton == act_period)) ||
                     ((state == LOW)  && (cnt == '0));
        stop_now   = stop || stop_lat;
        nxt_period = pending ? shd_period : act_period;
        nxt_ton    = pending ? shd_ton    : act_ton;
    end

    // Config capture plus the IDLE/PHASE/HIGH/LOW sequencer with its registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            clk_out    <= 1'b0;
            cfg_err    <= 1'b0;
            act_period <= '0;
            act_ton    <= '0;
            act_phase  <= '0;
            shd_period <= '0;
            shd_ton    <= '0;
            shd_phase  <= '0;
            pending    <= 1'b0;
            stop_lat   <= 1'b0;
            cfg_loaded <= 1'b0;
        end else begin
            cfg_err <= 1'b0;

            if (cfg_fire) begin
                if (cfg_bad) begin
                    cfg_err <= 1'b1;
                end else if (state == IDLE) begin
                    act_period <= cfg.cfg_period;
                    act_ton    <= cfg.cfg_ton;
                    act_phase  <= cfg.cfg_phase;
                    cfg_loaded <= 1'b1;
                end else begin
                    shd_period <= cfg.cfg_period;
                    shd_ton    <= cfg.cfg_ton;
                    shd_phase  <= cfg.cfg_phase;
                    pending    <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    clk_out  <= 1'b0;
                    stop_lat <= 1'b0;
                    if (start && !stop) begin
                        if (!cfg_loaded) begin
                            cfg_err <= 1'b1;
                        end else if (act_phase != '0) begin
                            state <= PHASE;
                            cnt   <= act_phase - ONE;
                        end else begin
                            state   <= entry_state(act_ton);
                            cnt     <= entry_cnt(act_period, act_ton);
                            clk_out <= (act_ton != '0);
                        end
                    end
                end

                PHASE: begin
                    if (stop) begin
                        state <= IDLE;
                        if (pending) begin
                            act_period <= shd_period;
                            act_ton    <= shd_ton;
                            act_phase  <= shd_phase;
                            pending    <= 1'b0;
                        end
                    end else if (cnt == '0) begin
                        state   <= entry_state(act_ton);
                        cnt     <= entry_cnt(act_period, act_ton);
                        clk_out <= (act_ton != '0);
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end

                HIGH, LOW: begin
                    if (stop) begin
                        stop_lat <= 1'b1;
                    end
                    if (boundary) begin
                        if (pending) begin
                            act_period <= shd_period;
                            act_ton    <= shd_ton;
                            act_phase  <= shd_phase;
                            pending    <= 1'b0;
                        end
                        if (stop_now) begin
                            state    <= IDLE;
                            clk_out  <= 1'b0;
                            stop_lat <= 1'b0;
                        end else begin
                            state   <= entry_state(nxt_ton);
                            cnt     <= entry_cnt(nxt_period, nxt_ton);
                            clk_out <= (nxt_ton != '0);
                        end
                    end else if (cnt == '0) begin
                        state   <= LOW;
                        cnt     <= act_period - act_ton - ONE;
                        clk_out <= 1'b0;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef CLKGEN_SCHED_PERIOD_CNT_EN
    // Count every completed period, wrapping naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if (boundary) begin
            period_cnt <= period_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_clkgen_sched.sv
// Self-checking bench for clkgen_sched: the expected per-cycle waveform
// (clk_out, busy, cfg_ready, cfg_err) is pushed to a scoreboard queue as each
// scenario is planned and popped/compared one entry per clock.
module tb_clkgen_sched;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic clk_out;
        logic busy;
        logic cfg_ready;
        logic cfg_err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stop  = 1'b0;
    logic clk_out;
    logic busy;
    logic cfg_err;
`ifdef CLKGEN_SCHED_PERIOD_CNT_EN
    logic [31:0] period_cnt;
`endif

    exp_t sb[$];
    int   num_checks = 0;
    int   num_fails  = 0;

    clkgen_sched_if #(.CNT_W(CNT_W)) cfg_bus ();

    clkgen_sched #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg     (cfg_bus),
        .start   (start),
        .stop    (stop),
        .clk_out (clk_out),
        .busy    (busy),
        .cfg_err (cfg_err)
`ifdef CLKGEN_SCHED_PERIOD_CNT_EN
        ,
        .period_cnt (period_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic expectCycle(input logic c, input logic b, input logic r, input logic e);
        exp_t x;
        x.clk_out   = c;
        x.busy      = b;
        x.cfg_ready = r;
        x.cfg_err   = e;
        sb.push_back(x);
    endtask

    // Whole periods: ton high cycles then period-ton low cycles, running, ready.
    task automatic expectPeriods(input int p, input int t, input int n);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < p; j++) expectCycle(j < t, 1'b1, 1'b1, 1'b0);
        end
    endtask

    task automatic expectIdle(input int n);
        for (int k = 0; k < n; k++) expectCycle(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic compareFront();
        exp_t e;
        if (sb.size() == 0) begin
            checkOutput("sb_level", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            checkOutput("clk_out",   32'(clk_out),           32'(e.clk_out));
            checkOutput("busy",      32'(busy),              32'(e.busy));
            checkOutput("cfg_ready", 32'(cfg_bus.cfg_ready), 32'(e.cfg_ready));
            checkOutput("cfg_err",   32'(cfg_err),           32'(e.cfg_err));
        end
    endtask

    // Drive one cycle of inputs, let the edge sample them, then compare 1 ns later.
    task automatic applyStimulus(input logic s, input logic sp, input logic cv,
                                 input int p, input int t, input int ph);
        start              = s;
        stop               = sp;
        cfg_bus.cfg_valid  = cv;
        cfg_bus.cfg_period = CNT_W'(p);
        cfg_bus.cfg_ton    = CNT_W'(t);
        cfg_bus.cfg_phase  = CNT_W'(ph);
        @(posedge clk);
        #1;
        start             = 1'b0;
        stop              = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        compareFront();
    endtask

    task automatic loadCfg(input int p, input int t, input int ph);
        expectCycle(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, p, t, ph);
    endtask

    // Start at cycle 0, optional extra start, stop and mid-run config at given cycles (-1 = none).
    task automatic runSchedule(input int n, input int restart_at, input int stop_at,
                               input int cfg_at, input int p, input int t, input int ph);
        for (int i = 0; i < n; i++) begin
            applyStimulus((i == 0) || (i == restart_at), i == stop_at, i == cfg_at, p, t, ph);
        end
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cfg_bus.cfg_valid  = 1'b0;
        cfg_bus.cfg_period = '0;
        cfg_bus.cfg_ton    = '0;
        cfg_bus.cfg_phase  = '0;

        // Reset values while rst_n is held low
        #12;
        checkOutput("rst_clk_out",   32'(clk_out),           32'd0);
        checkOutput("rst_busy",      32'(busy),              32'd0);
        checkOutput("rst_cfg_err",   32'(cfg_err),           32'd0);
        checkOutput("rst_cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);
`ifdef CLKGEN_SCHED_PERIOD_CNT_EN
        checkOutput("rst_period_cnt", period_cnt, 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] start without configuration after reset");
        expectCycle(1'b0, 1'b0, 1'b1, 1'b1);
        expectIdle(1);
        runSchedule(2, -1, -1, -1, 0, 0, 0);

        $display("[TB] 10/5 phase 0, stop mid-HIGH of third period");
        loadCfg(10, 5, 0);
        expectPeriods(10, 5, 3);
        expectIdle(4);
        runSchedule(34, -1, 22, -1, 0, 0, 0);

        $display("[TB] 4/1 phase 3, ignored restart while busy");
        loadCfg(4, 1, 3);
        for (int k = 0; k < 3; k++) expectCycle(1'b0, 1'b1, 1'b1, 1'b0);
        expectPeriods(4, 1, 3);
        expectIdle(2);
        runSchedule(17, 5, 12, -1, 0, 0, 0);

        $display("[TB] stop during PHASE");
        loadCfg(4, 1, 5);
        for (int k = 0; k < 2; k++) expectCycle(1'b0, 1'b1, 1'b1, 1'b0);
        expectIdle(2);
        runSchedule(4, -1, 2, -1, 0, 0, 0);

        $display("[TB] reconfigure 10/5 -> 6/2 mid-HIGH");
        loadCfg(10, 5, 0);
        for (int k = 0; k < 2; k++) expectCycle(1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 2; k < 5; k++) expectCycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 5; k < 10; k++) expectCycle(1'b0, 1'b1, 1'b0, 1'b0);
        expectPeriods(6, 2, 3);
        expectIdle(3);
        runSchedule(31, -1, 23, 2, 6, 2, 0);

        $display("[TB] ton==0 and ton==period");
        loadCfg(3, 0, 0);
        expectPeriods(3, 0, 2);
        expectIdle(2);
        runSchedule(8, -1, 4, -1, 0, 0, 0);
        loadCfg(3, 3, 0);
        expectPeriods(3, 3, 2);
        expectIdle(2);
        runSchedule(8, -1, 4, -1, 0, 0, 0);

        $display("[TB] rejected configurations and start without active config");
        resetDut();
        expectCycle(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 0, 0);
        expectIdle(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
        expectCycle(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 4, 8, 0);
        expectIdle(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
        expectCycle(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0);
        expectIdle(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);

        $display("[TB] three periods of 4/2, then start+stop together in IDLE");
        loadCfg(4, 2, 0);
        expectPeriods(4, 2, 3);
        expectIdle(2);
        runSchedule(14, -1, 9, -1, 0, 0, 0);
`ifdef CLKGEN_SCHED_PERIOD_CNT_EN
        checkOutput("period_cnt", period_cnt, 32'd3);
`endif
        expectIdle(3);
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
`ifdef CLKGEN_SCHED_PERIOD_CNT_EN
        checkOutput("period_cnt_hold", period_cnt, 32'd3);
`endif

        $display("[TB] asynchronous reset mid-HIGH");
        loadCfg(10, 5, 0);
        for (int k = 0; k < 3; k++) expectCycle(1'b1, 1'b1, 1'b1, 1'b0);
        runSchedule(3, -1, -1, -1, 0, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_clk_out",   32'(clk_out),           32'd0);
        checkOutput("async_rst_busy",      32'(busy),              32'd0);
        checkOutput("async_rst_cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
